// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and a word-wide data memory.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
//
// state | meaning
// IDLE  | waiting for req; latches the request and checks alignment
// READ  | word address on dm_addr, read in flight
// LATCH | dm_dout valid; load result or merged store word captured
// WRITE | dm_we high for one cycle
// RESP  | done pulse, err if the request was rejected
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        wr_q;
  logic        sext_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign bad = (size == 2'b11) ||
               ((size == 2'b10) && (addr[1:0] != 2'b00)) ||
               ((size == 2'b01) && addr[0]);

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == RESP);
  assign err   = (state_q == RESP) && err_q;
  assign dm_we = (state_q == WRITE) && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad)                        state_d = RESP;
          else if (wr && size == 2'b10)   state_d = WRITE;
          else                            state_d = READ;
        end
      end
      READ:    state_d = LATCH;
      LATCH:   state_d = wr_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    byte_sel = dm_dout[{lane_q, 3'b000} +: 8];
    half_sel = dm_dout[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = dm_dout;
    endcase
    merged = dm_dout;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (size_q == 2'b01)
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      wdata_q <= '0;
      rdata   <= '0;
      dm_addr <= '0;
      dm_din  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            sext_q  <= sext;
            size_q  <= size;
            lane_q  <= addr[1:0];
            wdata_q <= wdata[15:0];
            err_q   <= bad;
            dm_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (wr && size == 2'b10)
              dm_din <= wdata;
          end
        end
        LATCH: begin
          if (wr_q) dm_din <= merged;
          else      rdata  <= load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec scenarios plus random traffic,
// checked against a byte-array reference memory and latency rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err, dm_we;
  logic [31:0] rdata, dm_din;
  logic [9:0]  dm_addr;
  logic [31:0] dm_dout;

  logic [31:0] dmem [256];
  logic        mem_clr;
  logic [7:0]  ref_mem [1024];
  logic [31:0] model_rdata;
  int          errors = 0;
  int          checks = 0;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: dout follows the address by one cycle.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
    end else if (dm_we) begin
      dmem[dm_addr[9:2]] <= dm_din;
    end
    dm_dout <= dmem[dm_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] a);
    int b;
    b = {a[9:2], 2'b00};
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic do_op(input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [9:0] a, input logic [31:0] wd);
    logic        is_bad;
    int          exp_lat, exp_we, exp_wek, k, we_cnt, we_k, ai;
    logic [31:0] v;
    ai = a;
    is_bad = (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd1 && a[0]);
    if (is_bad)          begin exp_lat = 1; exp_we = 0; end
    else if (w && sz == 2'd2) begin exp_lat = 2; exp_we = 1; end
    else if (w)          begin exp_lat = 4; exp_we = 1; end
    else                 begin exp_lat = 3; exp_we = 0; end
    exp_wek = exp_we ? exp_lat - 1 : 0;
    if (!is_bad) begin
      if (w) begin
        ref_mem[ai] = wd[7:0];
        if (sz != 2'd0) ref_mem[ai+1] = wd[15:8];
        if (sz == 2'd2) begin ref_mem[ai+2] = wd[23:16]; ref_mem[ai+3] = wd[31:24]; end
      end else begin
        if (sz == 2'd0) begin
          v = ref_mem[ai];
          if (sx && v[7]) v = v - 32'd256;
        end else if (sz == 2'd1) begin
          v = {ref_mem[ai+1], ref_mem[ai]};
          if (sx && v[15]) v = v - 32'd65536;
        end else begin
          v = {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
        end
        model_rdata = v;
      end
    end
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    k = 1; we_cnt = 0; we_k = 0;
    while (done !== 1'b1 && k < 10) begin
      if (dm_we === 1'b1) begin we_cnt++; we_k = k; end
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"},   k, exp_lat);
    chk({tag, "_err"},   {31'd0, err}, {31'd0, is_bad});
    chk({tag, "_wecnt"}, we_cnt, exp_we);
    chk({tag, "_wecyc"}, we_k, exp_wek);
    chk({tag, "_rdata"}, rdata, model_rdata);
    chk({tag, "_mem"},   dmem[a[9:2]], ref_word(a));
    @(posedge clk); #1;
    chk({tag, "_idle"},  {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int dn;
    rst = 1'b1; mem_clr = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
    sext = 1'b0; addr = '0; wdata = '0;
    model_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_err",    {31'd0, err}, 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_dmaddr", {22'd0, dm_addr}, 32'd0);
    chk("rst_dmdin",  dm_din, 32'd0);
    chk("rst_dmwe",   {31'd0, dm_we}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Word store / load round trip, then sub-word loads.
    do_op("sw10", 1, 2'd2, 0, 10'h010, 32'h12345678);
    do_op("lw10", 0, 2'd2, 0, 10'h010, 32'h0);
    chk("lw10_const", rdata, 32'h12345678);
    do_op("lb11", 0, 2'd0, 1, 10'h011, 32'h0);
    chk("lb11_const", rdata, 32'h00000056);
    do_op("lh12", 0, 2'd1, 1, 10'h012, 32'h0);
    chk("lh12_const", rdata, 32'h00001234);
    do_op("sb13", 1, 2'd0, 0, 10'h013, 32'hFFFFFF80);
    do_op("lbu13", 0, 2'd0, 0, 10'h013, 32'h0);
    chk("lbu13_const", rdata, 32'h00000080);
    do_op("lb13", 0, 2'd0, 1, 10'h013, 32'h0);
    chk("lb13_const", rdata, 32'hFFFFFF80);

    // Read-modify-write merges.
    do_op("sw10b", 1, 2'd2, 0, 10'h010, 32'h12345678);
    do_op("sb12", 1, 2'd0, 0, 10'h012, 32'h000000AB);
    do_op("lw10b", 0, 2'd2, 0, 10'h010, 32'h0);
    chk("sb12_const", rdata, 32'h12AB5678);
    do_op("sh10", 1, 2'd1, 0, 10'h010, 32'h0000BEEF);
    do_op("lw10c", 0, 2'd2, 0, 10'h010, 32'h0);
    chk("sh10_const", rdata, 32'h12ABBEEF);

    // Rejected requests.
    do_op("lh13", 0, 2'd1, 1, 10'h013, 32'h0);
    do_op("sw12", 1, 2'd2, 0, 10'h012, 32'hDEADBEEF);
    do_op("sz11", 0, 2'd3, 0, 10'h000, 32'h0);

    // Reset during WRITE of an sb suppresses the write.
    do_op("sw20", 1, 2'd2, 0, 10'h020, 32'hA5A55A5A);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; size = 2'd0; sext = 1'b0; addr = 10'h022; wdata = 32'h000000CD;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_pre_we", {31'd0, dm_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_we_gated", {31'd0, dm_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 32'h0;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    chk("rstw_dmdin", dm_din, 32'd0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    chk("rstw_nodone", dn, 0);
    chk("rstw_mem", dmem[8'h08], ref_word(10'h020));
    chk("rstw_mem_const", dmem[8'h08], 32'hA5A55A5A);

    // req held high while busy: only one transaction.
    req = 1'b1; wr = 1'b0; size = 2'd2; sext = 1'b0; addr = 10'h010;
    @(posedge clk); #1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dn++;
      if (i == 2) req = 1'b0;
      @(posedge clk); #1;
    end
    model_rdata = ref_word(10'h010);
    chk("hold_dones", dn, 1);
    chk("hold_rdata", rdata, model_rdata);

    // Random traffic over a small window so loads hit earlier stores.
    for (int n = 0; n < 80; n++) begin
      do_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
